// File: rtl/button_event_unit_pkg.sv
// Shared definitions for the button event unit: channel FSM encoding and button indices.
package button_event_unit_pkg;

  localparam int NUM_BTN = 4;

  localparam int BTN_SOUTH = 0;
  localparam int BTN_NORTH = 1;
  localparam int BTN_WEST  = 2;
  localparam int BTN_EAST  = 3;

  typedef enum logic [1:0] {
    ST_UP        = 2'd0,
    ST_WAIT_DOWN = 2'd1,
    ST_DOWN      = 2'd2,
    ST_WAIT_UP   = 2'd3
  } btn_state_e;

endpackage

// File: rtl/button_event_unit_if.sv
// Button/ack bundle between the board-side driver and the event unit.
interface button_event_unit_if;
  import button_event_unit_pkg::*;

  logic [NUM_BTN-1:0] button;
  logic [NUM_BTN-1:0] ack;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] overrun;

  modport master (output button, ack, input level, pending, overrun);
  modport slave  (input button, ack, output level, pending, overrun);
endinterface

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchronizer, 4-state debounce FSM and hold counter.
module button_debounce
  import button_event_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic             in;
  btn_state_e       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  assign in = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      state <= ST_UP;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      state <= state_nx;
      cnt   <= cnt_nx;
      level <= (state_nx == ST_DOWN) || (state_nx == ST_WAIT_UP);
    end
  end

  // press is combinational so the top latches it on the same edge the FSM enters DOWN
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    press    = 1'b0;
    case (state)
      ST_UP: if (in) begin
        state_nx = ST_WAIT_DOWN;
        cnt_nx   = '0;
      end
      ST_WAIT_DOWN: begin
        if (!in) begin
          state_nx = ST_UP;
          cnt_nx   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nx = ST_DOWN;
          press    = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_DOWN: if (!in) begin
        state_nx = ST_WAIT_UP;
        cnt_nx   = '0;
      end
      ST_WAIT_UP: begin
        if (in) begin
          state_nx = ST_DOWN;
          cnt_nx   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nx = ST_UP;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = ST_UP;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: rtl/button_event_unit.sv
// Debounces four board buttons and latches press events until the CPU acknowledges them.
module button_event_unit
  import button_event_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  button_event_unit_if.slave  bus
);

  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] overrun;
  logic [NUM_BTN-1:0] ack_hit;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (bus.button[i]),
      .level (level[i]),
      .press (press[i])
    );
  end

  // an ack only counts against an event that is actually pending
  assign ack_hit = bus.ack & pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      pending <= press | (pending & ~bus.ack);
      overrun <= (press & pending & ~bus.ack) | (overrun & ~ack_hit);
    end
  end

  assign bus.level   = level;
  assign bus.pending = pending;
  assign bus.overrun = overrun;

endmodule

// File: tb/tb_button_event_unit.sv
// Scoreboard bench: a window-based button model predicts level/pending/overrun every cycle.
module tb_button_event_unit;
  localparam int D  = 4;
  localparam int HD = D + 3;

  typedef struct packed {
    logic [3:0] level;
    logic [3:0] pending;
    logic [3:0] overrun;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  obs_t exp_q[$];

  logic [3:0]    m_lvl = '0, m_pend = '0, m_ovr = '0;
  logic [HD-1:0] hist [4];

  button_event_unit_if bif ();

  button_event_unit #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got lvl/pend/ovr=%h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // The debounced level flips once the last D+1 synchronized samples all disagree with it;
  // a synchronized sample at edge t is the raw value seen two edges earlier.
  task automatic model(input logic [3:0] b, input logic [3:0] a, input logic r);
    for (int i = 0; i < 4; i++) begin
      logic all_opp;
      logic pr;
      if (!r) begin
        hist[i]   = '0;
        m_lvl[i]  = 1'b0;
        m_pend[i] = 1'b0;
        m_ovr[i]  = 1'b0;
      end else begin
        hist[i] = {hist[i][HD-2:0], b[i]};
        all_opp = 1'b1;
        for (int k = 2; k <= 2 + D; k++)
          if (hist[i][k] == m_lvl[i]) all_opp = 1'b0;
        pr = 1'b0;
        if (all_opp) begin
          m_lvl[i] = ~m_lvl[i];
          pr = m_lvl[i];
        end
        if (pr) begin
          if (m_pend[i] && !a[i])     m_ovr[i] = 1'b1;
          else if (m_pend[i] && a[i]) m_ovr[i] = 1'b0;
          m_pend[i] = 1'b1;
        end else if (a[i] && m_pend[i]) begin
          m_pend[i] = 1'b0;
          m_ovr[i]  = 1'b0;
        end
      end
    end
    exp_q.push_back('{level: m_lvl, pending: m_pend, overrun: m_ovr});
  endtask

  task automatic step(input logic [3:0] b, input logic [3:0] a, input logic r);
    @(negedge clk);
    bif.button = b;
    bif.ack    = a;
    rst_n      = r;
    model(b, a, r);
  endtask

  task automatic run(input logic [3:0] b, input logic [3:0] a, input int n);
    for (int i = 0; i < n; i++) step(b, a, 1'b1);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("scoreboard", {bif.level, bif.pending, bif.overrun}, e);
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    for (int i = 0; i < 4; i++) hist[i] = '0;
    bif.button = '0;
    bif.ack    = '0;
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    chk("reset_state", {bif.level, bif.pending, bif.overrun}, 12'h000);

    // EAST held from edge 0: level/pending rise at edge 6, not before
    step(4'b1000, 4'b0000, 1'b1);
    run(4'b1000, 4'b0000, 5);
    after_edge();
    chk("east_edge5", {bif.level, bif.pending, bif.overrun}, 12'h000);
    step(4'b1000, 4'b0000, 1'b1);
    after_edge();
    chk("east_edge6", {bif.level, bif.pending, bif.overrun}, {4'b1000, 4'b1000, 4'b0000});

    // ack clears, release, re-press
    step(4'b1000, 4'b1000, 1'b1);
    after_edge();
    chk("east_ack", {bif.level, bif.pending, bif.overrun}, {4'b1000, 4'b0000, 4'b0000});
    run(4'b0000, 4'b0000, 8);
    run(4'b1000, 4'b0000, 8);
    after_edge();
    chk("east_repress", {bif.level, bif.pending, bif.overrun}, {4'b1000, 4'b1000, 4'b0000});
    step(4'b0000, 4'b1000, 1'b1);
    run(4'b0000, 4'b0000, 8);

    // WEST bounces shorter than the debounce window
    run(4'b0100, 4'b0000, 3);
    run(4'b0000, 4'b0000, 2);
    run(4'b0100, 4'b0000, 3);
    run(4'b0000, 4'b0000, 6);
    after_edge();
    chk("west_bounce", {bif.level, bif.pending, bif.overrun}, 12'h000);

    // SOUTH press, release, press again unacked -> overrun; ack clears both
    run(4'b0001, 4'b0000, 8);
    run(4'b0000, 4'b0000, 8);
    run(4'b0001, 4'b0000, 8);
    after_edge();
    chk("south_overrun", {bif.level, bif.pending, bif.overrun}, {4'b0001, 4'b0001, 4'b0001});
    step(4'b0001, 4'b0001, 1'b1);
    after_edge();
    chk("south_ack", {bif.level, bif.pending, bif.overrun}, {4'b0001, 4'b0000, 4'b0000});
    run(4'b0000, 4'b0000, 8);

    // NORTH: build overrun, then new press lands on the same edge as the ack
    run(4'b0010, 4'b0000, 8);
    run(4'b0000, 4'b0000, 8);
    run(4'b0010, 4'b0000, 8);
    run(4'b0000, 4'b0000, 8);
    run(4'b0010, 4'b0000, 6);
    step(4'b0010, 4'b0010, 1'b1);
    after_edge();
    chk("north_press_ack", {bif.level, bif.pending, bif.overrun}, {4'b0010, 4'b0010, 4'b0000});
    step(4'b0010, 4'b0010, 1'b1);
    run(4'b0000, 4'b0000, 8);

    // all four pending, WEST mid-debounce, then async reset
    run(4'b1111, 4'b0000, 8);
    run(4'b0000, 4'b0000, 8);
    run(4'b0100, 4'b0000, 4);
    step(4'b0100, 4'b0000, 1'b0);
    #1;
    chk("reset_async", {bif.level, bif.pending, bif.overrun}, 12'h000);
    step(4'b0100, 4'b0000, 1'b0);
    step(4'b0100, 4'b0000, 1'b1);
    run(4'b0100, 4'b0000, 5);
    after_edge();
    chk("rst_redetect_edge5", {bif.level, bif.pending, bif.overrun}, 12'h000);
    step(4'b0100, 4'b0000, 1'b1);
    after_edge();
    chk("rst_redetect_edge6", {bif.level, bif.pending, bif.overrun}, {4'b0100, 4'b0100, 4'b0000});

    // randomized phase: independent toggling buttons, random acks, rare resets
    begin
      logic [3:0] b = 4'b0100;
      logic [3:0] a;
      logic       r;
      for (int c = 0; c < 3000; c++) begin
        for (int i = 0; i < 4; i++)
          if ($urandom_range(6) == 0) b[i] = ~b[i];
        for (int i = 0; i < 4; i++)
          a[i] = ($urandom_range(5) == 0);
        r = ($urandom_range(399) != 0);
        step(b, a, r);
      end
    end

    after_edge();
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
